// File: rtl/sfifo_ctrl_pkg.sv
// Shared defaults, output-buffer occupancy codes and the round-robin pointer helper
// used by the sfifo_ctrl controller and its arbiter.
package sfifo_ctrl_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int NREQ_DEF   = 2;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   function automatic int rr_next(input int idx, input int nreq);
      return (idx + 1) % nreq;
   endfunction
endpackage

// File: rtl/sfifo_rr_arb.sv
// Combinational round-robin arbiter: picks the first requester at or above ptr,
// wrapping modulo NREQ; the one-hot grant is only driven while advance is high.
module sfifo_rr_arb
   import sfifo_ctrl_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic             advance,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant
);
   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = advance;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sfifo_ctrl.sv
// Shares one registered-read FIFO among NREQ producers and turns its one-cycle read
// latency into a full-rate valid/ready stream through a 2-entry output buffer.
module sfifo_ctrl
   import sfifo_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREQ   = NREQ_DEF,
   parameter int DEPTH  = 8,
   parameter int LVL_W  = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   Rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   input  logic                   out_ready,
   output logic                   fifo_Rst,
   output logic                   fifo_EN,
   output logic                   fifo_WR_EN,
   output logic [DATA_W-1:0]      fifo_dataIn,
   output logic                   fifo_RD_EN,
   input  logic [DATA_W-1:0]      fifo_dataOut,
   input  logic                   fifo_FULL,
   input  logic                   fifo_EMPTY,
   output logic [LVL_W-1:0]       level
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [NREQ-1:0]   grant;
   logic [PTR_W-1:0]  grant_idx;
   logic [1:0]        occ_q, occ_d;
   logic              inflight_q, inflight_d;
   logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              pop, level_up, level_dn;

   assign fifo_Rst   = ~Rst;
   assign fifo_EN    = 1'b1;
   assign fifo_WR_EN = (|req_valid) & ~fifo_FULL & Rst;

   sfifo_rr_arb #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
      .req     (req_valid),
      .advance (fifo_WR_EN),
      .ptr     (ptr_q),
      .grant   (grant)
   );

   assign req_ready = grant;

   always_comb begin
      fifo_dataIn = '0;
      grant_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            fifo_dataIn = req_data[i*DATA_W +: DATA_W];
            grant_idx   = PTR_W'(i);
         end
      end
      ptr_d = fifo_WR_EN ? PTR_W'(rr_next(int'(grant_idx), NREQ)) : ptr_q;
   end

   // Reads are issued only when the returning word is guaranteed a buffer slot.
   assign out_valid  = (occ_q != OCC_EMPTY) & Rst;
   assign out_data   = head_q;
   assign pop        = out_valid & out_ready;
   assign fifo_RD_EN = ~fifo_EMPTY & Rst &
                       (({1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);
   assign inflight_d = fifo_RD_EN;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (pop) begin
         head_d = tail_q;
         occ_d  = occ_q - 2'd1;
      end
      if (inflight_q) begin
         if (occ_d == OCC_EMPTY) head_d = fifo_dataOut;
         else                    tail_d = fifo_dataOut;
         occ_d = occ_d + 2'd1;
      end
   end

   assign level_up = fifo_WR_EN & ~fifo_RD_EN;
   assign level_dn = fifo_RD_EN & ~fifo_WR_EN;
   assign level    = level_q;

   always_comb begin
      level_d = level_q;
      if (level_up && level_q != LVL_W'(DEPTH)) level_d = level_q + 1'b1;
      else if (level_dn && level_q != '0)       level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!Rst) begin
         ptr_q      <= '0;
         occ_q      <= OCC_EMPTY;
         inflight_q <= 1'b0;
         level_q    <= '0;
      end else begin
         ptr_q      <= ptr_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         level_q    <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         assert (!(level_up && level_q == LVL_W'(DEPTH)));
         assert (!(level_dn && level_q == '0));
         assert (occ_q <= OCC_TWO);
      end
   end
endmodule

// File: tb/tb_sfifo_ctrl.sv
// Bench for sfifo_ctrl: behavioural FIFO, round-robin reference model and an
// in-order scoreboard of accepted producer words against consumer output.
module tb_sfifo_ctrl;
   logic        clk = 1'b0;
   logic        Rst;
   logic [1:0]  req_valid;
   logic [63:0] req_data;
   logic [1:0]  req_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        fifo_Rst, fifo_EN, fifo_WR_EN, fifo_RD_EN;
   logic [31:0] fifo_dataIn;
   logic [31:0] m_dout = 32'h0;
   logic        m_full = 1'b0;
   logic        m_empty = 1'b1;
   logic [3:0]  level;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   logic [31:0] src0[$];
   logic [31:0] src1[$];
   logic [1:0]  hs_s = 2'b00;
   int          acc_cnt = 0;
   int          pop_cnt = 0;
   int          ref_ptr = 0;
   logic        pred_wr_s = 1'b0;
   int          pred_g_s = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = 32'h0;

   logic [31:0] m_mem [8];
   int          m_wp = 0, m_rp = 0, m_count = 0, m_next;
   logic        m_wr, m_rd;

   always #5 clk = ~clk;

   sfifo_ctrl #(.DATA_W(32), .NREQ(2), .DEPTH(8)) dut (
      .clk(clk), .Rst(Rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .fifo_Rst(fifo_Rst), .fifo_EN(fifo_EN), .fifo_WR_EN(fifo_WR_EN),
      .fifo_dataIn(fifo_dataIn), .fifo_RD_EN(fifo_RD_EN), .fifo_dataOut(m_dout),
      .fifo_FULL(m_full), .fifo_EMPTY(m_empty), .level(level)
   );

   // External FIFO per its contract: registered read data and flags.
   assign m_wr   = fifo_WR_EN & ~m_full;
   assign m_rd   = fifo_RD_EN & ~m_empty;
   assign m_next = m_count + int'(m_wr) - int'(m_rd);

   always @(posedge clk) begin
      if (fifo_Rst) begin
         m_wp <= 0; m_rp <= 0; m_count <= 0; m_full <= 1'b0; m_empty <= 1'b1;
      end else begin
         if (m_wr) begin m_mem[m_wp] <= fifo_dataIn; m_wp <= (m_wp + 1) % 8; end
         if (m_rd) begin m_dout <= m_mem[m_rp]; m_rp <= (m_rp + 1) % 8; end
         m_count <= m_next;
         m_full  <= (m_next == 8);
         m_empty <= (m_next == 0);
      end
   end

   always @(posedge clk) begin
      if (!Rst)           ref_ptr <= 0;
      else if (pred_wr_s) ref_ptr <= (pred_g_s + 1) % 2;
   end

   // Runs at every negedge: arbitration model, level, stall stability, scoreboard.
   task automatic monitor();
      logic       pwr;
      int         pg;
      logic [1:0] pready;
      logic [31:0] e;
      pwr = (|req_valid) && !m_full && Rst;
      pg  = 0;
      if (req_valid[ref_ptr]) pg = ref_ptr;
      else if (req_valid[(ref_ptr + 1) % 2]) pg = (ref_ptr + 1) % 2;
      pready = pwr ? (2'b01 << pg) : 2'b00;
      n_tests++;
      if (req_ready !== pready) begin
         n_fail++;
         $display("FAIL arb_ready t=%0t: req_ready=%b required %b", $time, req_ready, pready);
      end
      n_tests++;
      if (level !== m_count[3:0]) begin
         n_fail++;
         $display("FAIL level t=%0t: level=%0d required %0d", $time, level, m_count);
      end
      n_tests++;
      if ((fifo_RD_EN & m_empty) !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_when_empty t=%0t: fifo_RD_EN=%b with EMPTY=1, required 0", $time, fifo_RD_EN);
      end
      if (prev_stall && Rst) begin
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== prev_data) begin
            n_fail++;
            $display("FAIL stall_stable t=%0t: out_valid=%b out_data=%h required 1/%h",
                     $time, out_valid, out_data, prev_data);
         end
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
         pop_cnt++;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_word t=%0t: out_data=%h required no output", $time, out_data);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
               n_fail++;
               $display("FAIL out_data t=%0t: out_data=%h required %h", $time, out_data, e);
            end
         end
      end
      if (pwr) exp_q.push_back(req_data[pg*32 +: 32]);
      if (!Rst) exp_q.delete();
      hs_s      = req_valid & req_ready;
      acc_cnt  += $countones(hs_s);
      pred_wr_s = pwr;
      pred_g_s  = pg;
   endtask

   task automatic drive_producers();
      if (hs_s[0] && src0.size() > 0) void'(src0.pop_front());
      if (hs_s[1] && src1.size() > 0) void'(src1.pop_front());
      hs_s = 2'b00;
      req_valid[0]    = (src0.size() > 0);
      req_valid[1]    = (src1.size() > 0);
      req_data[31:0]  = (src0.size() > 0) ? src0[0] : 32'h0;
      req_data[63:32] = (src1.size() > 0) ? src1[0] : 32'h0;
   endtask

   task automatic to_neg(); @(negedge clk); monitor(); endtask
   task automatic to_pos(); @(posedge clk); #1; drive_producers(); endtask
   task automatic tick();   to_neg(); to_pos(); endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || src0.size() != 0 || src1.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      n_tests++;
      if (n >= budget) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d words outstanding after %0d cycles, required 0", exp_q.size(), n);
      end
   endtask

   task automatic test_reset();
      Rst = 1'b0; out_ready = 1'b1;
      src0.push_back(32'hDEAD0001);
      drive_producers();
      for (int c = 0; c < 2; c++) begin
         to_neg();
         n_tests++;
         if ({out_valid, req_ready, fifo_WR_EN, fifo_RD_EN, fifo_Rst, fifo_EN} !== 7'b0000011) begin
            n_fail++;
            $display("FAIL reset_outputs: {ov,rr,wr,rd,frst,en}=%b required 0000011",
                     {out_valid, req_ready, fifo_WR_EN, fifo_RD_EN, fifo_Rst, fifo_EN});
         end
         n_tests++;
         if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: level=%0d required 0", level); end
         to_pos();
      end
      Rst = 1'b1;
      to_neg();
      n_tests++;
      if (fifo_RD_EN !== 1'b0 || fifo_Rst !== 1'b0) begin
         n_fail++;
         $display("FAIL release_empty: fifo_RD_EN=%b fifo_Rst=%b required 0/0", fifo_RD_EN, fifo_Rst);
      end
      n_tests++;
      if (fifo_WR_EN !== 1'b1) begin n_fail++; $display("FAIL release_write: fifo_WR_EN=%b required 1", fifo_WR_EN); end
      to_pos();
      drain(20);
   endtask

   task automatic test_single();
      int lmax = 0;
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) src0.push_back(32'hAAAA0000 + i);
      drive_producers();
      to_neg(); to_pos();
      for (int c = 0; c < 2; c++) begin
         to_neg();
         n_tests++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid cycle %0d: out_valid=%b required 0", c, out_valid); end
         to_pos();
      end
      to_neg();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'hAAAA0001) begin
         n_fail++;
         $display("FAIL first_word: out_valid=%b out_data=%h required 1/aaaa0001", out_valid, out_data);
      end
      to_pos();
      for (int c = 0; c < 4; c++) begin
         to_neg();
         if (int'(level) > lmax) lmax = int'(level);
         n_tests++;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL throughput word %0d: out_valid=%b required 1", c + 2, out_valid); end
         to_pos();
      end
      drain(20);
      n_tests++;
      if (lmax > 2 || level !== 4'd0) begin
         n_fail++;
         $display("FAIL single_level: peak=%0d final=%0d required <=2 and 0", lmax, level);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] eg;
      Rst = 1'b0; to_neg(); to_pos(); Rst = 1'b1;
      out_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         src0.push_back(32'hA0000000 + n);
         src1.push_back(32'hB0000000 + n);
      end
      drive_producers();
      for (int k = 0; k < 8; k++) begin
         to_neg();
         eg = (k % 2 == 0) ? 2'b01 : 2'b10;
         n_tests++;
         if (req_ready !== eg) begin n_fail++; $display("FAIL rr_grant %0d: req_ready=%b required %b", k, req_ready, eg); end
         to_pos();
      end
      drain(30);
   endtask

   task automatic test_full();
      int n = 0;
      int acc0, pop0;
      out_ready = 1'b0;
      acc0 = acc_cnt;
      for (int i = 0; i < 6; i++) begin
         src0.push_back(32'hC0000000 + i);
         src1.push_back(32'hD0000000 + i);
      end
      drive_producers();
      while (!m_full && n < 40) begin tick(); n++; end
      n_tests++;
      if (!m_full) begin n_fail++; $display("FAIL full_timeout: FULL=%b after %0d cycles, required 1", m_full, n); end
      for (int c = 0; c < 3; c++) begin
         to_neg();
         n_tests++;
         if (level !== 4'd8 || req_ready !== 2'b00 || fifo_WR_EN !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_hold: level=%0d req_ready=%b wr=%b ov=%b required 8/00/0/1",
                     level, req_ready, fifo_WR_EN, out_valid);
         end
         n_tests++;
         if (acc_cnt - acc0 != 10) begin n_fail++; $display("FAIL full_count: accepted=%0d required 10", acc_cnt - acc0); end
         to_pos();
      end
      out_ready = 1'b1;
      pop0 = pop_cnt;
      drain(60);
      n_tests++;
      if (pop_cnt - pop0 != 12) begin n_fail++; $display("FAIL full_drain: delivered=%0d required 12", pop_cnt - pop0); end
   endtask

   task automatic test_toggle();
      int n = 0;
      int pop0 = pop_cnt;
      out_ready = 1'b1;
      for (int i = 1; i <= 6; i++) src1.push_back(32'hE0000000 + i);
      drive_producers();
      while ((exp_q.size() != 0 || src1.size() != 0) && n < 60) begin
         tick();
         out_ready = ~out_ready;
         n++;
      end
      out_ready = 1'b1;
      n_tests++;
      if (pop_cnt - pop0 != 6) begin n_fail++; $display("FAIL toggle_count: delivered=%0d required 6", pop_cnt - pop0); end
   endtask

   task automatic test_reset_midop();
      int n = 0;
      int pop0;
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) src0.push_back(32'hF0000000 + i);
      drive_producers();
      while ((m_count != 4 || src0.size() != 0) && n < 30) begin tick(); n++; end
      n_tests++;
      if (m_count != 4) begin n_fail++; $display("FAIL midop_fill: fifo words=%0d required 4", m_count); end
      out_ready = 1'b1;
      to_neg();
      n_tests++;
      if (out_valid !== 1'b1 || fifo_RD_EN !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_pop: out_valid=%b fifo_RD_EN=%b required 1/1", out_valid, fifo_RD_EN);
      end
      to_pos();
      out_ready = 1'b0; Rst = 1'b0;
      to_neg();
      n_tests++;
      if (level !== 4'd3) begin n_fail++; $display("FAIL midop_level: level=%0d required 3", level); end
      to_pos();
      to_neg();
      n_tests++;
      if (out_valid !== 1'b0 || level !== 4'd0 || fifo_Rst !== 1'b1 || fifo_RD_EN !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_reset: ov=%b level=%0d fifo_Rst=%b rd=%b required 0/0/1/0",
                  out_valid, level, fifo_Rst, fifo_RD_EN);
      end
      to_pos();
      Rst = 1'b1; out_ready = 1'b1;
      src1.push_back(32'h90000001);
      src1.push_back(32'h90000002);
      drive_producers();
      pop0 = pop_cnt;
      drain(30);
      repeat (3) tick();
      n_tests++;
      if (pop_cnt - pop0 != 2) begin n_fail++; $display("FAIL midop_after: delivered=%0d required 2", pop_cnt - pop0); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      Rst = 1'b0; out_ready = 1'b0; req_valid = 2'b00; req_data = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_toggle();
      test_reset_midop();
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
